// File: rtl/irq_prio_encoder_148.sv
// Eight-line interrupt request encoder with 74x148-style priority (line 7 highest).
// Synchronises requests, holds them pending and presents one code at a time over a valid/ack handshake.
module irq_prio_encoder_148 #(
   parameter int N           = 8,
   parameter int CODE_W      = 3,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_MODE   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N-1:0]      req,
   input  logic [N-1:0]      mask,
   input  logic              ei,
   input  logic              clr_all,
   input  logic              irq_ack,
   output logic              irq_valid,
   output logic [CODE_W-1:0] irq_code,
   output logic [N-1:0]      pending_o,
   output logic              gs,
   output logic              eo
);

   typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

   state_t              state, state_nxt;
   logic [N-1:0]        sync_q [SYNC_STAGES];
   logic [N-1:0]        req_s;
   logic [N-1:0]        req_prev;
   logic [N-1:0]        req_rise;
   logic [N-1:0]        pending, pending_nxt;
   logic [N-1:0]        eligible;
   logic [N-1:0]        ack_clr;
   logic                any_eligible;
   logic                ack_fire;
   logic                valid_nxt;
   logic [CODE_W-1:0]   code_nxt;

   // Ascending scan so the highest set index is the one that sticks.
   function automatic logic [CODE_W-1:0] hi_index(input logic [N-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) begin
         if (v[i]) idx = i[CODE_W-1:0];
      end
      return idx;
   endfunction

   // Input synchroniser and edge history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
         req_prev <= '0;
      end else begin
         sync_q[0] <= req;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
         req_prev <= req_s;
      end
   end

   assign req_s    = sync_q[SYNC_STAGES-1];
   assign req_rise = req_s & ~req_prev;

   assign eligible     = pending & mask;
   assign any_eligible = |eligible;
   assign ack_fire     = (state == PRESENT) && irq_ack;
   assign ack_clr      = ack_fire ? ({{(N-1){1'b0}}, 1'b1} << irq_code) : '0;

   // Pending update: clr_all beats a new edge, a new edge beats the ack clear.
   always_comb begin
      pending_nxt = pending;
      if (EDGE_MODE != 0) begin
         pending_nxt = (pending & ~ack_clr) | req_rise;
         if (clr_all) pending_nxt = '0;
      end else begin
         pending_nxt = req_s;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pending <= '0;
      else        pending <= pending_nxt;
   end

   // Handshake FSM
   always_comb begin
      state_nxt = state;
      valid_nxt = irq_valid;
      code_nxt  = irq_code;
      case (state)
         IDLE: begin
            if (ei && any_eligible) begin
               code_nxt  = hi_index(eligible);
               valid_nxt = 1'b1;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (irq_ack) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         irq_valid <= 1'b0;
         irq_code  <= '0;
      end else begin
         state     <= state_nxt;
         irq_valid <= valid_nxt;
         irq_code  <= code_nxt;
      end
   end

   assign pending_o = pending;
   assign gs        = ei & any_eligible;
   assign eo        = ei & ~any_eligible;

endmodule

// File: tb/tb_irq_prio_encoder_148.sv
// Directed bench for irq_prio_encoder_148: stimulus queues expected codes, a monitor checks each presentation.
module tb_irq_prio_encoder_148;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic [7:0] mask;
   logic       ei;
   logic       clr_all;
   logic       irq_ack;
   logic       irq_valid;
   logic [2:0] irq_code;
   logic [7:0] pending_o;
   logic       gs;
   logic       eo;

   int total = 0;
   int bad   = 0;
   int exp_q[$];

   irq_prio_encoder_148 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .mask      (mask),
      .ei        (ei),
      .clr_all   (clr_all),
      .irq_ack   (irq_ack),
      .irq_valid (irq_valid),
      .irq_code  (irq_code),
      .pending_o (pending_o),
      .gs        (gs),
      .eo        (eo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_valid(input string name, input int max_cyc);
      int n;
      n = 0;
      while (irq_valid !== 1'b1 && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (irq_valid !== 1'b1) begin
         bad++;
         $display("FAIL %s: irq_valid still %b after %0d cycles, expected 1", name, irq_valid, max_cyc);
      end
   endtask

   task automatic do_ack();
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
   endtask

   // Monitor: every new presentation is compared against the scoreboard
   initial begin
      logic prev_valid;
      int   exp_code;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (irq_valid === 1'b1 && prev_valid !== 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_code: got %0d expected none", irq_code);
            end else begin
               exp_code = exp_q.pop_front();
               if (irq_code !== exp_code[2:0]) begin
                  bad++;
                  $display("FAIL code: got %0d expected %0d", irq_code, exp_code);
               end
            end
         end
         prev_valid = irq_valid;
      end
   end

   initial begin
      rst_n   = 1'b0;
      req     = 8'h00;
      mask    = 8'hFF;
      ei      = 1'b1;
      clr_all = 1'b0;
      irq_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid",   {31'd0, irq_valid}, 32'd0);
      check("rst_code",    {29'd0, irq_code},  32'd0);
      check("rst_pending", {24'd0, pending_o}, 32'd0);
      check("rst_gs",      {31'd0, gs},        32'd0);
      check("rst_eo",      {31'd0, eo},        32'd1);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: single request, latency and ack
      exp_q.push_back(2);
      req = 8'h04;
      repeat (3) @(negedge clk);
      check("t1_pending_k2", {24'd0, pending_o}, 32'h04);
      check("t1_valid_k2",   {31'd0, irq_valid}, 32'd0);
      req = 8'h00;
      @(negedge clk);
      check("t1_valid_k3",   {31'd0, irq_valid}, 32'd1);
      do_ack();
      check("t1_valid_ack",  {31'd0, irq_valid}, 32'd0);
      check("t1_pending_ack", {24'd0, pending_o}, 32'h00);
      repeat (2) @(negedge clk);

      // 2: simultaneous 7 and 0
      exp_q.push_back(7);
      exp_q.push_back(0);
      req = 8'h81;
      repeat (2) @(negedge clk);
      req = 8'h00;
      wait_valid("t2_first", 8);
      do_ack();
      check("t2_idle_gap",  {31'd0, irq_valid}, 32'd0);
      check("t2_pend_gap",  {24'd0, pending_o}, 32'h01);
      @(negedge clk);
      check("t2_second",    {31'd0, irq_valid}, 32'd1);
      do_ack();
      check("t2_pending",   {24'd0, pending_o}, 32'h00);
      repeat (2) @(negedge clk);

      // 3: masked line 7 stays pending
      exp_q.push_back(0);
      mask = 8'h7F;
      req  = 8'h81;
      repeat (2) @(negedge clk);
      req  = 8'h00;
      wait_valid("t3_first", 8);
      do_ack();
      check("t3_pending_masked", {24'd0, pending_o}, 32'h80);
      repeat (3) @(negedge clk);
      check("t3_valid_masked",   {31'd0, irq_valid}, 32'd0);
      check("t3_gs_masked",      {31'd0, gs},        32'd0);
      exp_q.push_back(7);
      mask = 8'hFF;
      wait_valid("t3_unmask", 4);
      do_ack();
      check("t3_pending", {24'd0, pending_o}, 32'h00);
      repeat (2) @(negedge clk);

      // 4: new edge on the acked line lands on the ack edge
      exp_q.push_back(3);
      exp_q.push_back(3);
      req = 8'h08;
      @(negedge clk);
      req = 8'h00;
      wait_valid("t4_first", 8);
      repeat (2) @(negedge clk);
      req = 8'h08;
      @(negedge clk);
      req = 8'h00;
      @(negedge clk);
      do_ack();
      check("t4_pending_kept", {24'd0, pending_o}, 32'h08);
      check("t4_valid_gap",    {31'd0, irq_valid}, 32'd0);
      @(negedge clk);
      check("t4_represent",    {31'd0, irq_valid}, 32'd1);
      do_ack();
      check("t4_pending", {24'd0, pending_o}, 32'h00);
      repeat (2) @(negedge clk);

      // 5: ei gates presentation
      ei  = 1'b0;
      req = 8'h10;
      repeat (2) @(negedge clk);
      req = 8'h00;
      repeat (4) @(negedge clk);
      check("t5_valid", {31'd0, irq_valid}, 32'd0);
      check("t5_gs",    {31'd0, gs},        32'd0);
      check("t5_eo",    {31'd0, eo},        32'd0);
      check("t5_pending", {24'd0, pending_o}, 32'h10);
      exp_q.push_back(4);
      ei = 1'b1;
      wait_valid("t5_enable", 4);
      check("t5_gs_on", {31'd0, gs}, 32'd1);
      do_ack();
      check("t5_eo_empty", {31'd0, eo}, 32'd1);
      repeat (2) @(negedge clk);

      // 6: async reset while presenting
      exp_q.push_back(5);
      req = 8'h20;
      repeat (2) @(negedge clk);
      req = 8'h00;
      wait_valid("t6_first", 8);
      check("t6_code_before", {29'd0, irq_code}, 32'd5);
      #2 rst_n = 1'b0;
      #1;
      check("t6_valid_rst",   {31'd0, irq_valid}, 32'd0);
      check("t6_code_rst",    {29'd0, irq_code},  32'd0);
      check("t6_pending_rst", {24'd0, pending_o}, 32'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("t6_idle_after", {31'd0, irq_valid}, 32'd0);

      check("scoreboard_empty", exp_q.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
